book_cmd_scheduler: RTL and testbench
=====================================

# book_cmd_scheduler

Sequences decoded ITCH order events (add / delete / execute) from the ITCH parser into the order book engine, one command per valid/ready handshake. Absorbs bursts in an in-order queue so the engine can take multiple cycles per command, drops and counts events on overflow, and flushes on MoldUDP64 packet loss. Sits in the 250 MHz domain between `itch_parser` and `order_book_engine`.

## Interface
- `DEPTH`, 16: queue entries; power of two, ≥ 2. Total capacity is DEPTH plus one output register.
- `clkIn`  in  1  250 MHz clock.
- `rstIn`  in  1  asynchronous, active-high reset.
- `addValidIn`  in  1  add-order event strobe.
- `delValidIn`  in  1  delete-order event strobe.
- `execValidIn`  in  1  execute-order event strobe.
- `refNumIn`  in  64  order reference number.
- `locateIn`  in  16  stock locate.
- `priceIn`  in  32  price.
- `sharesIn`  in  64  shares.
- `buySellIn`  in  1  side, 1 = buy.
- `packetLostIn`  in  1  sequence-gap flush request.
- `cmdReadyIn`  in  1  engine can accept a command this cycle.
- `cmdValidOut`  out  1  command valid.
- `cmdTypeOut`  out  2  command type: 0 = add, 1 = delete, 2 = execute. Value 3 is never driven.
- `cmdRefNumOut`, `cmdLocateOut`, `cmdPriceOut`, `cmdSharesOut`, `cmdBuySellOut`  out  64/16/32/64/1  command payload.
- `occupancyOut`  out  $clog2(DEPTH)+1  number of queue entries; excludes the output register.
- `dropCountOut`  out  16  events dropped on overflow; saturates at 0xFFFF.
- `overflowOut`  out  1  sticky; set on the first drop.
- `multiEventErrOut`  out  1  sticky; set when more than one event strobe is high in the same cycle.
- `resyncOut`  out  1  one-cycle pulse on the cycle after a flush.

## Operation
- Entry is 179 bits: type plus all payload fields, captured at the edge where the strobe is sampled.
- Event arbitration:
  - An event is any cycle in which any of the three strobes is high.
  - If more than one strobe is high, enqueue one entry with priority add > delete > execute, and set `multiEventErrOut`.
- Queue: circular buffer with read/write pointers carrying an extra wrap bit. Empty when the pointers are equal; full when the indices match and the wrap bits differ.
- Output register:
  - Loads from the queue head (a pop) when it is empty, or when `cmdValidOut & cmdReadyIn`.
  - Otherwise it holds, and the payload must stay stable while `cmdValidOut=1 & cmdReadyIn=0`.
- Push condition: event present and (not full, or a pop occurs in the same cycle). Push and pop in the same cycle leave occupancy unchanged.
- Overflow: an event arrives while full with no pop in the same cycle.
  - The event is discarded.
  - `dropCountOut` increments, saturating at 0xFFFF.
  - `overflowOut` is set.
  - Queue contents are untouched.
- Flush (`packetLostIn=1` sampled):
  - Queue pointers reset and `cmdValidOut` clears at that edge.
  - Any event arriving in the same cycle is discarded and is not counted as a drop.
  - A command handshaken in that same cycle (`cmdValidOut & cmdReadyIn`) counts as delivered.
  - `resyncOut` is high for exactly the next cycle.
- Sticky flags and `dropCountOut` clear only on `rstIn`; they are not cleared by a flush.
- No reordering: commands leave in arrival order.

## Timing
- Reset values:
  - `cmdValidOut=0`.
  - All `cmd*Out` payload outputs = 0.
  - `occupancyOut=0`, `dropCountOut=0`.
  - `overflowOut=0`, `multiEventErrOut=0`, `resyncOut=0`.
  - Pointers = 0.
- Latency:
  - Event sampled at edge N enters the queue.
  - If the output register is empty or consumed at edge N+1, it loads there.
  - `cmdValidOut` is therefore high in the cycle after edge N+1, i.e. 2 cycles after the strobe cycle.
- Throughput: one command per cycle with `cmdReadyIn` held high.
- `occupancyOut` is a registered output; it reflects the pushes and pops of edge N after edge N.
- `cmdReadyIn` may combinationally affect the pop and full-accept decisions. All outputs are registered.
- Reset asserted mid-burst: all state clears immediately (asynchronously). No command is emitted until an event arrives after deassertion.

## Test plan
- Single add (ref=0x11, locate=5, price=1000, shares=100, buy), `cmdReadyIn=1` → exactly one cycle with `cmdValidOut=1`, two cycles after the strobe, carrying type 0 and the identical payload.
- 20 back-to-back events with DEPTH=16 and `cmdReadyIn=0`, then ready released → 17 commands delivered in order, `dropCountOut=3`, `overflowOut=1`, `occupancyOut` peaks at 16.
- `cmdReadyIn` toggling 1-0-1-0 during a 6-event burst → all 6 commands delivered in order; payload stable during stall cycles; no drops.
- `packetLostIn` pulse with 5 entries queued plus one held output → `cmdValidOut=0` and `occupancyOut=0` next cycle, `resyncOut` a single cycle, `dropCountOut` unchanged; events arriving after the flush are delivered normally.
- `addValidIn` and `execValidIn` high in the same cycle → one type-0 command delivered, `multiEventErrOut=1`.
- Full queue, with a push and a pop in the same cycle → the event is accepted, occupancy stays 16, no drop counted.

Source files
------------

// File: rtl/book_cmd_scheduler.sv
// book_cmd_scheduler
//
// Takes decoded ITCH order events (add / delete / execute) from the parser
// and hands them to the order book engine as one command per valid/ready
// handshake. Bursts are held in an in-order circular queue so the engine
// may take several cycles per command. Events that arrive while the queue
// is full are dropped and counted. A MoldUDP64 packet loss flushes
// everything that has not yet been handed over.
//
// Ports:
//   clkIn, rstIn            250 MHz clock, asynchronous active-high reset
//   addValidIn/delValidIn/  event strobes; add wins over delete, which
//   execValidIn             wins over execute, when several are high
//   refNumIn, locateIn,     event payload, captured with the strobe
//   priceIn, sharesIn,
//   buySellIn
//   packetLostIn            flush request (sequence gap)
//   cmdReadyIn              engine accepts the presented command
//   cmdValidOut, cmd*Out    registered command and payload
//   occupancyOut            queue entries, excluding the output register
//   dropCountOut            saturating count of overflow drops
//   overflowOut             sticky, set on the first drop
//   multiEventErrOut        sticky, set when strobes collide
//   resyncOut               one-cycle pulse after a flush

module book_cmd_scheduler #(
  parameter int DEPTH = 16
) (
  input  logic                     clkIn,
  input  logic                     rstIn,
  input  logic                     addValidIn,
  input  logic                     delValidIn,
  input  logic                     execValidIn,
  input  logic [63:0]              refNumIn,
  input  logic [15:0]              locateIn,
  input  logic [31:0]              priceIn,
  input  logic [63:0]              sharesIn,
  input  logic                     buySellIn,
  input  logic                     packetLostIn,
  input  logic                     cmdReadyIn,
  output logic                     cmdValidOut,
  output logic [1:0]               cmdTypeOut,
  output logic [63:0]              cmdRefNumOut,
  output logic [15:0]              cmdLocateOut,
  output logic [31:0]              cmdPriceOut,
  output logic [63:0]              cmdSharesOut,
  output logic                     cmdBuySellOut,
  output logic [$clog2(DEPTH):0]   occupancyOut,
  output logic [15:0]              dropCountOut,
  output logic                     overflowOut,
  output logic                     multiEventErrOut,
  output logic                     resyncOut
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 179;

  localparam logic [1:0] TYPE_ADD  = 2'd0;
  localparam logic [1:0] TYPE_DEL  = 2'd1;
  localparam logic [1:0] TYPE_EXEC = 2'd2;

  // Queue storage; no reset needed since only entries between the
  // pointers are ever read.
  logic [EW-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  logic          any_event;
  logic          multi_event;
  logic [1:0]    ev_type;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] in_entry;
  logic [EW-1:0] head_entry;

  // Event decode and queue control. A pop refills the output register
  // whenever it is empty or being consumed. A full queue still accepts an
  // event when a pop frees the head slot in the same cycle. A flush
  // suppresses both pushing and drop accounting.
  always_comb begin
    any_event   = addValidIn | delValidIn | execValidIn;
    multi_event = (addValidIn & delValidIn) | (addValidIn & execValidIn) |
                  (delValidIn & execValidIn);
    ev_type     = TYPE_EXEC;
    if (addValidIn) begin
      ev_type = TYPE_ADD;
    end else if (delValidIn) begin
      ev_type = TYPE_DEL;
    end
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    pop        = !empty && (!cmdValidOut || cmdReadyIn);
    push       = any_event && (!full || pop) && !packetLostIn;
    drop       = any_event && full && !pop && !packetLostIn;
    in_entry   = {ev_type, refNumIn, locateIn, priceIn, sharesIn, buySellIn};
    head_entry = mem[rd_ptr[AW-1:0]];
  end

  // Queue write port. When full with a simultaneous pop the write index
  // equals the head index; the head is read before this edge, so the new
  // entry safely replaces it.
  always_ff @(posedge clkIn) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_entry;
    end
  end

  // Pointers and occupancy. Occupancy is kept as its own register so the
  // output comes straight from a flop.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancyOut <= '0;
    end else if (packetLostIn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancyOut <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occupancyOut <= occupancyOut + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Output register. Payload only changes on a pop, so it stays stable
  // while the engine stalls. A flush drops the held command; the payload
  // bits are left as they are since cmdValidOut qualifies them.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      cmdValidOut   <= 1'b0;
      cmdTypeOut    <= '0;
      cmdRefNumOut  <= '0;
      cmdLocateOut  <= '0;
      cmdPriceOut   <= '0;
      cmdSharesOut  <= '0;
      cmdBuySellOut <= 1'b0;
    end else if (packetLostIn) begin
      cmdValidOut <= 1'b0;
    end else if (pop) begin
      cmdValidOut   <= 1'b1;
      cmdTypeOut    <= head_entry[178:177];
      cmdRefNumOut  <= head_entry[176:113];
      cmdLocateOut  <= head_entry[112:97];
      cmdPriceOut   <= head_entry[96:65];
      cmdSharesOut  <= head_entry[64:1];
      cmdBuySellOut <= head_entry[0];
    end else if (cmdReadyIn) begin
      cmdValidOut <= 1'b0;
    end
  end

  // Status: drop counter saturates, error flags are sticky until reset and
  // survive a flush; resync simply echoes the flush one cycle later.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      dropCountOut     <= '0;
      overflowOut      <= 1'b0;
      multiEventErrOut <= 1'b0;
      resyncOut        <= 1'b0;
    end else begin
      if (drop) begin
        overflowOut <= 1'b1;
        if (dropCountOut != 16'hFFFF) begin
          dropCountOut <= dropCountOut + 16'd1;
        end
      end
      if (multi_event) begin
        multiEventErrOut <= 1'b1;
      end
      resyncOut <= packetLostIn;
    end
  end

endmodule

// File: tb/tb_book_cmd_scheduler.sv
// tb_book_cmd_scheduler
//
// Drives directed scenarios and a randomized burst into book_cmd_scheduler.
// A reference model tracks how many events sit in the queue and whether a
// command is presented; accepted commands go into an expected queue that a
// separate monitor consumes whenever the DUT presents a command.

module tb_book_cmd_scheduler;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [1:0]  typ;
    logic [63:0] ref_num;
    logic [15:0] locate;
    logic [31:0] price;
    logic [63:0] shares;
    logic        buy_sell;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        add_valid;
  logic        del_valid;
  logic        exec_valid;
  logic [63:0] ref_num;
  logic [15:0] locate;
  logic [31:0] price;
  logic [63:0] shares;
  logic        buy_sell;
  logic        packet_lost;
  logic        cmd_ready;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [63:0] cmd_ref_num;
  logic [15:0] cmd_locate;
  logic [31:0] cmd_price;
  logic [63:0] cmd_shares;
  logic        cmd_buy_sell;
  logic [$clog2(DEPTH):0] occupancy;
  logic [15:0] drop_count;
  logic        overflow;
  logic        multi_err;
  logic        resync;

  book_cmd_scheduler #(.DEPTH(DEPTH)) dut (
    .clkIn           (clk),
    .rstIn           (rst),
    .addValidIn      (add_valid),
    .delValidIn      (del_valid),
    .execValidIn     (exec_valid),
    .refNumIn        (ref_num),
    .locateIn        (locate),
    .priceIn         (price),
    .sharesIn        (shares),
    .buySellIn       (buy_sell),
    .packetLostIn    (packet_lost),
    .cmdReadyIn      (cmd_ready),
    .cmdValidOut     (cmd_valid),
    .cmdTypeOut      (cmd_type),
    .cmdRefNumOut    (cmd_ref_num),
    .cmdLocateOut    (cmd_locate),
    .cmdPriceOut     (cmd_price),
    .cmdSharesOut    (cmd_shares),
    .cmdBuySellOut   (cmd_buy_sell),
    .occupancyOut    (occupancy),
    .dropCountOut    (drop_count),
    .overflowOut     (overflow),
    .multiEventErrOut(multi_err),
    .resyncOut       (resync)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard: every command the DUT still owes, oldest first.
  cmd_t exp_q[$];

  // Reference model state: events waiting in the queue, command presented,
  // and the status the DUT should report.
  int m_q;
  bit m_v;
  int m_drop;
  bit m_ovf;
  bit m_multi;
  bit m_resync;
  int peak_occ;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [178:0] act,
                             input logic [178:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.typ      = 2'd0;
    c.ref_num  = {$urandom, $urandom};
    c.locate   = 16'($urandom);
    c.price    = $urandom;
    c.shares   = {$urandom, $urandom};
    c.buy_sell = 1'($urandom);
    return c;
  endfunction

  // Monitor: whenever a command is presented it must match the oldest owed
  // command; a handshake retires it. Checking on stall cycles too proves
  // the payload holds steady.
  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_cmd", {cmd_type, cmd_ref_num, cmd_locate, cmd_price,
                                       cmd_shares, cmd_buy_sell}, '1);
      end else begin
        checkOutput("cmd", {cmd_type, cmd_ref_num, cmd_locate, cmd_price,
                            cmd_shares, cmd_buy_sell}, exp_q[0]);
        if (cmd_ready) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One clock cycle of stimulus followed by the model step and status check.
  task automatic applyStimulus(input bit a, input bit d, input bit e,
                               input bit rdy, input bit flush, input cmd_t pay);
    cmd_t c;
    bit   ev;
    bit   pop;
    bit   acc;
    int   nstrobe;
    c          = pay;
    c.typ      = a ? 2'd0 : (d ? 2'd1 : 2'd2);
    add_valid  = a;
    del_valid  = d;
    exec_valid = e;
    ref_num    = pay.ref_num;
    locate     = pay.locate;
    price      = pay.price;
    shares     = pay.shares;
    buy_sell   = pay.buy_sell;
    cmd_ready  = rdy;
    packet_lost = flush;
    @(posedge clk);
    ev      = a | d | e;
    nstrobe = int'(a) + int'(d) + int'(e);
    if (nstrobe > 1) m_multi = 1'b1;
    pop = (m_q > 0) && (!m_v || rdy);
    if (flush) begin
      exp_q.delete();
      m_q = 0;
      m_v = 1'b0;
    end else begin
      acc = ev && ((m_q < DEPTH) || pop);
      if (ev && !acc) begin
        if (m_drop < 65535) m_drop++;
        m_ovf = 1'b1;
      end
      if (acc) exp_q.push_back(c);
      m_q = m_q + int'(acc) - int'(pop);
      m_v = pop || (m_v && !rdy);
    end
    m_resync = flush;
    #1;
    if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
    checkOutput("occupancy", 179'(occupancy), 179'(m_q));
    checkOutput("cmd_valid", 179'(cmd_valid), 179'(m_v));
    checkOutput("drop_count", 179'(drop_count), 179'(m_drop));
    checkOutput("overflow", 179'(overflow), 179'(m_ovf));
    checkOutput("multi_err", 179'(multi_err), 179'(m_multi));
    checkOutput("resync", 179'(resync), 179'(m_resync));
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0, rand_cmd());
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_q      = 0;
    m_v      = 1'b0;
    m_drop   = 0;
    m_ovf    = 1'b0;
    m_multi  = 1'b0;
    m_resync = 1'b0;
    peak_occ = 0;
  endtask

  // Asynchronous reset taken away from a clock edge, checked before the
  // next edge, released just after one.
  task automatic do_reset();
    rst = 1'b1;
    add_valid = 1'b0;
    del_valid = 1'b0;
    exec_valid = 1'b0;
    packet_lost = 1'b0;
    #2;
    model_clear();
    checkOutput("rst_valid", 179'(cmd_valid), 179'(0));
    checkOutput("rst_payload", {cmd_type, cmd_ref_num, cmd_locate, cmd_price,
                                cmd_shares, cmd_buy_sell}, '0);
    checkOutput("rst_status", 179'({occupancy, drop_count, overflow, multi_err, resync}),
                179'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_q != 0 || m_v) && n < 200) begin
      idle(1'b1);
      n++;
    end
    checkOutput("drain_done", 179'(exp_q.size()), 179'(0));
  endtask

  initial begin
    cmd_t c;
    rst = 1'b1;
    cmd_ready = 1'b0;
    ref_num = '0;
    locate = '0;
    price = '0;
    shares = '0;
    buy_sell = 1'b0;
    model_clear();
    #12;
    do_reset();

    // Single add with a fixed payload.
    c = '{typ: 2'd0, ref_num: 64'h11, locate: 16'd5, price: 32'd1000,
          shares: 64'd100, buy_sell: 1'b1};
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c);
    repeat (4) idle(1'b1);

    // 20 back-to-back events while stalled, then release.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i % 3 == 0, i % 3 == 1, i % 3 == 2, 1'b0, 1'b0, rand_cmd());
    end
    checkOutput("burst_drops", 179'(drop_count), 179'(3));
    checkOutput("burst_peak", 179'(peak_occ), 179'(DEPTH));
    drain();

    // Ready toggling during a 6-event burst.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, i[0], !i[0], i[0] == 1'b0, 1'b0, rand_cmd());
    end
    for (int i = 0; i < 8; i++) idle(i[0] == 1'b0);
    drain();
    checkOutput("toggle_drops", 179'(drop_count), 179'(0));

    // Flush with five queued and one held command.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rand_cmd());
    idle(1'b0);
    checkOutput("pre_flush_occ", 179'(occupancy), 179'(5));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, rand_cmd());
    idle(1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, rand_cmd());
    drain();

    // Colliding strobes: add and execute together.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, rand_cmd());
    drain();

    // Full queue, push and pop in the same cycle.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rand_cmd());
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rand_cmd());
    checkOutput("full_pushpop_occ", 179'(occupancy), 179'(DEPTH));
    drain();

    // Randomized traffic with stalls, collisions, flushes and one reset.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b000;
      applyStimulus(s[0], s[1], s[2], $urandom_range(0, 3) != 0 && !(i % 100 > 60 && i % 100 < 85),
                    $urandom_range(0, 63) == 0, rand_cmd());
      if (i == 300) do_reset();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
